// File: rtl/lcd_bus_sequencer_pkg.sv
// Shared constants, state encodings and helpers for the HD44780 4-bit bus sequencer.
package lcd_pkg;

    // Default timing, in clock cycles
    localparam int DEF_SETUP_CYC = 1;
    localparam int DEF_EHI_CYC   = 2;
    localparam int DEF_WAIT_CYC  = 4;
    localparam int DEF_LONG_CYC  = 64;
    localparam int DEF_POR_CYC   = 128;
    localparam int DEF_CNT_W     = 8;

    // Sequencer states
    localparam logic [3:0] ST_POR_WAIT   = 4'd0;
    localparam logic [3:0] ST_INIT_SETUP = 4'd1;
    localparam logic [3:0] ST_INIT_EHI   = 4'd2;
    localparam logic [3:0] ST_INIT_HOLD  = 4'd3;
    localparam logic [3:0] ST_INIT_WAIT  = 4'd4;
    localparam logic [3:0] ST_IDLE       = 4'd5;
    localparam logic [3:0] ST_SETUP      = 4'd6;
    localparam logic [3:0] ST_EHI        = 4'd7;
    localparam logic [3:0] ST_HOLD       = 4'd8;
    localparam logic [3:0] ST_WAIT       = 4'd9;

    // Power-on nibbles that switch the controller into 4-bit mode; entry [0] goes out first
    localparam logic [3:0][3:0] INIT_NIBBLES = {4'h2, 4'h3, 4'h3, 4'h3};

    // Clear display (0x01) and return home (0x02/0x03) need the extended busy wait
    function automatic logic is_long_cmd(input logic rs, input logic [7:0] data);
        return !rs && (data == 8'h01 || data == 8'h02 || data == 8'h03);
    endfunction

endpackage

// File: rtl/lcd_bus_sequencer_if.sv
// Byte request handshake plus the LCD pin bundle driven by the sequencer.
interface lcd_bus_sequencer_if;
    logic       req_valid;
    logic       req_rs;
    logic [7:0] req_data;
    logic       req_ready;
    logic       init_done;
    logic       RS;
    logic       E;
    logic       D4;
    logic       D5;
    logic       D6;
    logic       D7;

    // Requester side: offers bytes, watches the pins
    modport master (
        output req_valid, req_rs, req_data,
        input  req_ready, init_done, RS, E, D4, D5, D6, D7
    );

    // Sequencer side
    modport slave (
        input  req_valid, req_rs, req_data,
        output req_ready, init_done, RS, E, D4, D5, D6, D7
    );
endinterface

// File: rtl/lcd_bus_sequencer_delay_counter.sv
// Loadable down-counter: loading N-1 keeps done low for N-1 cycles, so a
// phase that exits on done lasts exactly N cycles.
module lcd_delay_counter #(
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_load,
    input  logic [CNT_W-1:0] i_load_val,
    output logic             o_done
);
    logic [CNT_W-1:0] r_cnt;

    // Load has priority; otherwise count down and park at zero
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            r_cnt <= '0;
        else if (i_load)
            r_cnt <= i_load_val;
        else if (r_cnt != '0)
            r_cnt <= r_cnt - CNT_W'(1);
    end

    assign o_done = (r_cnt == '0);
endmodule

// File: rtl/lcd_bus_sequencer.sv
// HD44780 4-bit bus sequencer: power-on init, then byte writes as two
// nibble strobes with setup/hold framing and a post-write busy wait.
module lcd_bus_sequencer
    import lcd_pkg::*;
#(
    parameter int SETUP_CYC = DEF_SETUP_CYC,
    parameter int EHI_CYC   = DEF_EHI_CYC,
    parameter int WAIT_CYC  = DEF_WAIT_CYC,
    parameter int LONG_CYC  = DEF_LONG_CYC,
    parameter int POR_CYC   = DEF_POR_CYC,
    parameter int CNT_W     = DEF_CNT_W
) (
    input  logic                CLK,
    input  logic                RST,
    lcd_bus_sequencer_if.slave  bus
);
    // Every phase loads N-1 so that it spans exactly N cycles
    localparam logic [CNT_W-1:0] LD_SETUP = CNT_W'(SETUP_CYC - 1);
    localparam logic [CNT_W-1:0] LD_EHI   = CNT_W'(EHI_CYC - 1);
    localparam logic [CNT_W-1:0] LD_WAIT  = CNT_W'(WAIT_CYC - 1);
    localparam logic [CNT_W-1:0] LD_LONG  = CNT_W'(LONG_CYC - 1);
    localparam logic [CNT_W-1:0] LD_POR   = CNT_W'(POR_CYC - 1);

    logic [3:0]       r_state;
    logic             r_armed;     // POR count has been loaded
    logic [1:0]       r_idx;       // init nibble index
    logic             r_lo;        // low nibble of the byte in flight
    logic [3:0]       r_lo_nib;
    logic             r_long;
    logic             r_rs;
    logic [3:0]       r_d;
    logic             r_init_done;

    logic [3:0]       w_next;
    logic             w_load;
    logic [CNT_W-1:0] w_load_val;
    logic             w_done;
    logic             w_ready;
    logic             w_accept;
    logic [1:0]       w_idx_nxt;

    lcd_delay_counter #(.CNT_W(CNT_W)) u_cnt (
        .clk        (CLK),
        .rst        (RST),
        .i_load     (w_load),
        .i_load_val (w_load_val),
        .o_done     (w_done)
    );

    assign w_ready   = (r_state == ST_IDLE) && r_init_done;
    assign w_accept  = w_ready && bus.req_valid;
    assign w_idx_nxt = r_idx + 2'd1;

    // Next state and counter load; loads only happen on phase transitions
    always_comb begin
        w_next     = r_state;
        w_load     = 1'b0;
        w_load_val = '0;
        case (r_state)
            ST_POR_WAIT: begin
                if (!r_armed) begin
                    w_load     = 1'b1;
                    w_load_val = LD_POR;
                end else if (w_done) begin
                    w_next     = ST_INIT_SETUP;
                    w_load     = 1'b1;
                    w_load_val = LD_SETUP;
                end
            end
            ST_INIT_SETUP: if (w_done) begin
                w_next     = ST_INIT_EHI;
                w_load     = 1'b1;
                w_load_val = LD_EHI;
            end
            ST_INIT_EHI: if (w_done) begin
                w_next     = ST_INIT_HOLD;
                w_load     = 1'b1;
                w_load_val = '0;
            end
            ST_INIT_HOLD: if (w_done) begin
                w_next     = ST_INIT_WAIT;
                w_load     = 1'b1;
                w_load_val = LD_LONG;
            end
            ST_INIT_WAIT: if (w_done) begin
                if (r_idx == 2'd3) begin
                    w_next = ST_IDLE;
                end else begin
                    w_next     = ST_INIT_SETUP;
                    w_load     = 1'b1;
                    w_load_val = LD_SETUP;
                end
            end
            ST_IDLE: if (w_accept) begin
                w_next     = ST_SETUP;
                w_load     = 1'b1;
                w_load_val = LD_SETUP;
            end
            ST_SETUP: if (w_done) begin
                w_next     = ST_EHI;
                w_load     = 1'b1;
                w_load_val = LD_EHI;
            end
            ST_EHI: if (w_done) begin
                w_next     = ST_HOLD;
                w_load     = 1'b1;
                w_load_val = '0;
            end
            ST_HOLD: if (w_done) begin
                w_load = 1'b1;
                if (!r_lo) begin
                    w_next     = ST_SETUP;
                    w_load_val = LD_SETUP;
                end else begin
                    w_next     = ST_WAIT;
                    w_load_val = r_long ? LD_LONG : LD_WAIT;
                end
            end
            ST_WAIT: if (w_done) w_next = ST_IDLE;
            default: w_next = ST_POR_WAIT;
        endcase
    end

    // State and bus registers; RS/D only move when entering a SETUP phase (E low)
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_state     <= ST_POR_WAIT;
            r_armed     <= 1'b0;
            r_idx       <= 2'd0;
            r_lo        <= 1'b0;
            r_lo_nib    <= 4'd0;
            r_long      <= 1'b0;
            r_rs        <= 1'b0;
            r_d         <= 4'd0;
            r_init_done <= 1'b0;
        end else begin
            r_state <= w_next;
            if (r_state == ST_POR_WAIT)
                r_armed <= 1'b1;
            case (r_state)
                ST_POR_WAIT: if (w_next == ST_INIT_SETUP) begin
                    r_idx <= 2'd0;
                    r_rs  <= 1'b0;
                    r_d   <= INIT_NIBBLES[0];
                end
                ST_INIT_WAIT: begin
                    if (w_next == ST_INIT_SETUP) begin
                        r_idx <= w_idx_nxt;
                        r_d   <= INIT_NIBBLES[w_idx_nxt];
                    end else if (w_next == ST_IDLE) begin
                        r_init_done <= 1'b1;
                    end
                end
                ST_IDLE: if (w_accept) begin
                    r_rs     <= bus.req_rs;
                    r_d      <= bus.req_data[7:4];
                    r_lo_nib <= bus.req_data[3:0];
                    r_long   <= is_long_cmd(bus.req_rs, bus.req_data);
                    r_lo     <= 1'b0;
                end
                ST_HOLD: if (w_next == ST_SETUP) begin
                    r_d  <= r_lo_nib;
                    r_lo <= 1'b1;
                end
                default: ;
            endcase
        end
    end

    assign bus.req_ready = w_ready;
    assign bus.init_done = r_init_done;
    assign bus.E         = (r_state == ST_EHI) || (r_state == ST_INIT_EHI);
    assign bus.RS        = r_rs;
    assign bus.D4        = r_d[0];
    assign bus.D5        = r_d[1];
    assign bus.D6        = r_d[2];
    assign bus.D7        = r_d[3];
endmodule

// File: tb/tb_lcd_bus_sequencer.sv
// Bench for lcd_bus_sequencer: expected pin traces are expanded from the
// timing rules (setup/E-high/hold per nibble, busy wait per byte).
module tb_lcd_bus_sequencer;
    localparam int T_SETUP = 1;
    localparam int T_EHI   = 2;
    localparam int T_WAIT  = 4;
    localparam int T_LONG  = 64;
    localparam int T_POR   = 128;
    localparam int T_XFER  = 2 * (T_SETUP + T_EHI + 1);

    typedef struct packed {
        logic       e;
        logic       rs;
        logic [3:0] d;
        logic       rdy;
        logic       idn;
    } samp_t;

    typedef struct {
        logic       rs;
        logic [7:0] data;
        logic [3:0] hi;
        logic [3:0] lo;
        int         busy;
    } vec_t;

    logic CLK = 1'b0;
    logic RST = 1'b1;
    lcd_bus_sequencer_if bus();

    lcd_bus_sequencer dut (
        .CLK (CLK),
        .RST (RST),
        .bus (bus)
    );

    always #5 CLK = ~CLK;

    int    checks = 0;
    int    errors = 0;
    bit    chk_en = 1'b0;
    samp_t exp_q[$];
    vec_t  tbl[10];

    function automatic samp_t observe();
        return {bus.E, bus.RS, bus.D7, bus.D6, bus.D5, bus.D4, bus.req_ready, bus.init_done};
    endfunction

    function automatic void push(samp_t s, int n);
        for (int i = 0; i < n; i++) exp_q.push_back(s);
    endfunction

    function automatic void push_nib(logic rs, logic [3:0] d, logic idn);
        push({1'b0, rs, d, 1'b0, idn}, T_SETUP);
        push({1'b1, rs, d, 1'b0, idn}, T_EHI);
        push({1'b0, rs, d, 1'b0, idn}, 1);
    endfunction

    // Compare one sample per cycle; scramble requester inputs while busy
    task automatic run_q(input string name, input bit drop);
        samp_t x, got;
        int    cyc;
        cyc = 0;
        while (exp_q.size() > 0) begin
            x = exp_q.pop_front();
            @(posedge CLK); #1;
            got = observe();
            checks++;
            if (got !== x) begin
                errors++;
                $display("FAIL %s cyc %0d: got %b want %b", name, cyc, got, x);
            end
            cyc++;
            if (exp_q.size() > 0) begin
                @(negedge CLK);
                bus.req_data = 8'($urandom);
                bus.req_rs   = 1'($urandom);
                if (drop) bus.req_valid = 1'b0;
            end
        end
    endtask

    task automatic expect_init();
        logic [3:0] nibs [4];
        nibs = '{4'h3, 4'h3, 4'h3, 4'h2};
        push('0, T_POR);
        for (int n = 0; n < 4; n++) begin
            push_nib(1'b0, nibs[n], 1'b0);
            push({1'b0, 1'b0, nibs[n], 1'b0, 1'b0}, T_LONG);
        end
        push({1'b0, 1'b0, 4'h2, 1'b1, 1'b1}, 1);
        run_q("init", 1'b0);
    endtask

    // Offer a byte at the negedge; DUT is idle, so the next edge accepts it
    task automatic send(input logic rs, input logic [7:0] data, input logic [3:0] hi,
                        input logic [3:0] lo, input int busy, input bit drop, input string name);
        @(negedge CLK);
        bus.req_valid = 1'b1;
        bus.req_rs    = rs;
        bus.req_data  = data;
        push_nib(rs, hi, 1'b1);
        push_nib(rs, lo, 1'b1);
        push({1'b0, rs, lo, 1'b0, 1'b1}, busy - T_XFER);
        push({1'b0, rs, lo, 1'b1, 1'b1}, 1);
        run_q(name, drop);
    endtask

    // RS/D must hold through every E-high cycle and the cycle E falls
    logic       prev_e = 1'b0;
    logic [4:0] prev_bus = '0;
    always begin
        @(posedge CLK); #1;
        if (chk_en && !RST && prev_e) begin
            checks++;
            if ({bus.RS, bus.D7, bus.D6, bus.D5, bus.D4} !== prev_bus) begin
                errors++;
                $display("FAIL bus_stable: got %b want %b", {bus.RS, bus.D7, bus.D6, bus.D5, bus.D4}, prev_bus);
            end
        end
        prev_e   = bus.E;
        prev_bus = {bus.RS, bus.D7, bus.D6, bus.D5, bus.D4};
    end

    initial begin
        #3_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic       rs;
        logic [7:0] data;
        int         busy;
        int         k;
        samp_t      got;

        tbl = '{
            '{1'b1, 8'h48, 4'h4, 4'h8, 12},
            '{1'b0, 8'h01, 4'h0, 4'h1, 72},
            '{1'b0, 8'h0C, 4'h0, 4'hC, 12},
            '{1'b0, 8'h02, 4'h0, 4'h2, 72},
            '{1'b0, 8'h03, 4'h0, 4'h3, 72},
            '{1'b0, 8'h04, 4'h0, 4'h4, 12},
            '{1'b1, 8'h01, 4'h0, 4'h1, 12},
            '{1'b0, 8'h00, 4'h0, 4'h0, 12},
            '{1'b1, 8'hFF, 4'hF, 4'hF, 12},
            '{1'b0, 8'h80, 4'h8, 4'h0, 12}
        };

        bus.req_valid = 1'b0;
        bus.req_rs    = 1'b0;
        bus.req_data  = 8'h00;
        RST           = 1'b1;
        repeat (3) @(posedge CLK);
        #1;
        got = observe();
        checks++;
        if (got !== '0) begin
            errors++;
            $display("FAIL reset_state: got %b want %b", got, 8'b0);
        end

        @(negedge CLK);
        RST = 1'b0;
        expect_init();
        chk_en = 1'b1;

        // Directed vectors, valid dropped after acceptance
        for (int i = 0; i < 10; i++)
            send(tbl[i].rs, tbl[i].data, tbl[i].hi, tbl[i].lo, tbl[i].busy, 1'b1, $sformatf("vec%0d", i));

        // Random back-to-back stream, valid held, data scrambled mid-transfer
        for (int i = 0; i < 200; i++) begin
            rs   = 1'($urandom);
            data = (i % 16 == 5) ? 8'($urandom_range(0, 4)) : 8'($urandom);
            if (i % 16 == 5) rs = 1'b0;
            busy = T_XFER + ((rs == 1'b0 && data >= 8'h01 && data <= 8'h03) ? T_LONG : T_WAIT);
            send(rs, data, data[7:4], data[3:0], busy, 1'b0, $sformatf("rnd%0d", i));
        end

        // Reset in the middle of an E pulse
        @(negedge CLK);
        bus.req_valid = 1'b1;
        bus.req_rs    = 1'b1;
        bus.req_data  = 8'h5A;
        @(posedge CLK); #1;
        bus.req_valid = 1'b0;
        k = 0;
        while (!bus.E && k < 10) begin
            @(posedge CLK); #1;
            k++;
        end
        checks++;
        if (!bus.E) begin
            errors++;
            $display("FAIL e_rise_timeout: got E=%b want 1", bus.E);
        end
        chk_en = 1'b0;
        #2;
        RST = 1'b1;
        #1;
        got = observe();
        checks++;
        if (got !== '0) begin
            errors++;
            $display("FAIL async_reset: got %b want %b", got, 8'b0);
        end
        @(negedge CLK);
        @(negedge CLK);
        RST = 1'b0;
        expect_init();
        chk_en = 1'b1;
        send(1'b1, 8'h48, 4'h4, 4'h8, 12, 1'b1, "post_reset");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
